// File: rtl/mem_store_ctrl.sv
// mem_store_ctrl: write-direction RAM port.
// Takes one byte/half/word store from the load-store unit and writes it
// little-endian onto the 8-bit RAM bus, one byte per cycle. Bytes that land in
// the memory-mapped UART window are throttled by uart_full_in and a hold counter.
module mem_store_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int UART_HOLD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              st_valid_in,
    output logic              st_ready_out,
    input  logic [ADDR_W-1:0] st_addr_in,
    input  logic [31:0]       st_data_in,
    input  logic [1:0]        st_size_in,
    input  logic              uart_full_in,
    output logic              ram_wr_out,
    output logic [ADDR_W-1:0] ram_addr_out,
    output logic [7:0]        ram_data_out,
    output logic              st_done_out,
    output logic              busy_out
);

    localparam int HOLD_W = (UART_HOLD > 0) ? $clog2(UART_HOLD + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       data_q;
    logic [1:0]        idx;
    logic [1:0]        last_idx;
    logic [HOLD_W-1:0] hold_cnt;

    logic [ADDR_W-1:0] byte_addr;
    logic [7:0]        cur_byte;
    logic              is_io;
    logic              stall;

    assign st_ready_out = (state == S_IDLE);
    assign busy_out     = (state != S_IDLE);

    // Address and data of the byte due this cycle, plus whether the UART window
    // forces us to wait (full TX buffer or spacing after the previous IO byte).
    always_comb begin
        byte_addr = base_addr + ADDR_W'(idx);
        cur_byte  = data_q[{idx, 3'b000} +: 8];
        is_io     = (byte_addr[17:16] == 2'b11);
        stall     = is_io && (uart_full_in || (hold_cnt != '0));
    end

    // Store sequencer: accept in IDLE, emit one byte per rdy cycle in WRITE,
    // pulse done in DONE. rdy low freezes every register including outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            base_addr    <= '0;
            data_q       <= '0;
            idx          <= '0;
            last_idx     <= '0;
            hold_cnt     <= '0;
            ram_wr_out   <= 1'b0;
            ram_addr_out <= '0;
            ram_data_out <= '0;
            st_done_out  <= 1'b0;
        end else if (rdy) begin
            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
            case (state)
                S_IDLE: begin
                    ram_wr_out  <= 1'b0;
                    st_done_out <= 1'b0;
                    if (st_valid_in) begin
                        base_addr <= st_addr_in;
                        data_q    <= st_data_in;
                        idx       <= '0;
                        case (st_size_in)
                            2'd0:    last_idx <= 2'd0;
                            2'd1:    last_idx <= 2'd1;
                            default: last_idx <= 2'd3;
                        endcase
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    st_done_out <= 1'b0;
                    if (stall) begin
                        ram_wr_out <= 1'b0;
                    end else begin
                        ram_wr_out   <= 1'b1;
                        ram_addr_out <= byte_addr;
                        ram_data_out <= cur_byte;
                        idx          <= idx + 2'd1;
                        if (is_io) begin
                            hold_cnt <= HOLD_W'(UART_HOLD);
                        end
                        if (idx == last_idx) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    ram_wr_out  <= 1'b0;
                    st_done_out <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    ram_wr_out  <= 1'b0;
                    st_done_out <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
